ws2812b_stream: RTL and testbench

- Parametrised WS2812B-class serial LED driver: accepts whole pixel words over a valid/ready stream and serialises them MSB-first with configurable bit timing.
- Adds a one-entry holding register so consecutive pixels go out back-to-back with no gap.
- A flagged last pixel triggers an automatic reset/latch period; mid-frame starvation is detected.
- Sits between the pixel/frame generator and the LED data pin; replaces per-bit write0/write1 pulsing.

---
 rtl/ws2812b_stream_if.sv | 13 +
 rtl/ws2812b_stream.sv | 179 +++++++++++++++++
 tb/tb_ws2812b_stream.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_stream_if.sv
// Pixel stream handshake between the frame generator and the WS2812B serialiser.
// A word moves on a rising edge where pix_valid and pix_ready are both high.
interface ws2812b_stream_if #(
  parameter int BITS_PER_PIXEL = 24
);
  logic [BITS_PER_PIXEL-1:0] pix_data;
  logic                      pix_last;
  logic                      pix_valid;
  logic                      pix_ready;

  modport master (output pix_data, output pix_last, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_last, input pix_valid, output pix_ready);
endinterface

// File: rtl/ws2812b_stream.sv
// WS2812B-class LED driver: serialises whole pixel words MSB-first with programmable
// bit timing, a one-word holding register for gapless frames, and an automatic latch.
module ws2812b_stream #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int T_BIT_CYC      = 63,
  parameter int T1H_CYC        = 50,
  parameter int T0H_CYC        = 12,
  parameter int RESET_CYC      = 4000
) (
  input  logic                   clk_50Mhz,
  input  logic                   reset_n,
  ws2812b_stream_if.slave        pix,
  input  logic                   clear_err,
  output logic                   led_out,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   underrun
);

  localparam int CYC_W = (T_BIT_CYC > 1) ? $clog2(T_BIT_CYC) : 1;
  localparam int CNT_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
  localparam int IDX_W = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_BIT_CYC - 1);
  localparam logic [CYC_W-1:0] T1H_L    = CYC_W'(T1H_CYC);
  localparam logic [CYC_W-1:0] T0H_L    = CYC_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_PIXEL - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_STALL, S_LATCH} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [BITS_PER_PIXEL-1:0] r_hold_data;
  logic                      r_hold_last;
  logic                      r_hold_full;
  logic [BITS_PER_PIXEL-1:0] r_shift;
  logic                      r_cur_last;
  logic [IDX_W-1:0]          r_bit_idx;
  logic [CYC_W-1:0]          r_cyc;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_led;
  logic                      r_frame_done;
  logic                      r_underrun;

  logic w_accept;
  logic w_load;
  logic w_shift;
  logic w_cyc_inc;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_set_ur;
  logic w_done;
  logic w_led_nxt;
  logic w_bit_one;

  assign w_accept  = pix.pix_valid & ~r_hold_full;
  assign w_bit_one = r_shift[BITS_PER_PIXEL-1];

  always_ff @(posedge clk_50Mhz or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_cyc_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_set_ur    = 1'b0;
    w_done      = 1'b0;
    w_led_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_led_nxt = w_bit_one ? (r_cyc < T1H_L) : (r_cyc < T0H_L);
        if (r_cyc != CYC_LAST) begin
          w_cyc_inc = 1'b1;
        end else if (r_bit_idx != '0) begin
          w_shift = 1'b1;
        end else if (r_cur_last) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_LATCH;
        end else if (r_hold_full) begin
          // Next word follows the final bit with no idle cycle in between.
          w_load = 1'b1;
        end else begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end else if (r_cnt == CNT_LAST) begin
          w_set_ur    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_LATCH: begin
        if (r_cnt == CNT_LAST) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A write wins over an unload on the same edge so the new word is kept.
  always_ff @(posedge clk_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_data <= '0;
      r_hold_last <= 1'b0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_data <= pix.pix_data;
      r_hold_last <= pix.pix_last;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_cur_last <= 1'b0;
      r_bit_idx  <= '0;
      r_cyc      <= '0;
    end else if (w_load) begin
      r_shift    <= r_hold_data;
      r_cur_last <= r_hold_last;
      r_bit_idx  <= IDX_LAST;
      r_cyc      <= '0;
    end else if (w_shift) begin
      r_shift    <= r_shift << 1;
      r_bit_idx  <= r_bit_idx - 1'b1;
      r_cyc      <= '0;
    end else if (w_cyc_inc) begin
      r_cyc <= r_cyc + 1'b1;
    end
  end

  always_ff @(posedge clk_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_led        <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      r_led        <= w_led_nxt;
      r_frame_done <= w_done;
      if (w_set_ur)       r_underrun <= 1'b1;
      else if (clear_err) r_underrun <= 1'b0;
    end
  end

  assign pix.pix_ready = ~r_hold_full;
  assign led_out       = r_led;
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = r_frame_done;
  assign underrun      = r_underrun;

endmodule

// File: tb/tb_ws2812b_stream.sv
// Bench for ws2812b_stream: a default 24-bit instance and a fast 32-bit instance,
// with per-bit pulse widths scoreboarded against words accepted on the stream.
module tb_ws2812b_stream;

  localparam int BPP [2] = '{24, 32};
  localparam int TBIT[2] = '{63, 25};
  localparam int T1H [2] = '{50, 16};
  localparam int T0H [2] = '{12, 6};
  localparam int RST [2] = '{4000, 50};

  typedef struct { int hi; int lo; } pulse_t;
  typedef struct { logic [31:0] data; int ones; } vec_t;

  logic clk       = 1'b0;
  logic reset_n   = 1'b1;
  logic clear_err = 1'b0;
  logic led0, busy0, fd0, ur0;
  logic led1, busy1, fd1, ur1;

  ws2812b_stream_if #(.BITS_PER_PIXEL(24)) if0 ();
  ws2812b_stream_if #(.BITS_PER_PIXEL(32)) if1 ();

  ws2812b_stream dut0 (
    .clk_50Mhz(clk), .reset_n(reset_n), .pix(if0), .clear_err(clear_err),
    .led_out(led0), .busy(busy0), .frame_done(fd0), .underrun(ur0)
  );

  ws2812b_stream #(
    .BITS_PER_PIXEL(32), .T_BIT_CYC(25), .T1H_CYC(16), .T0H_CYC(6), .RESET_CYC(50)
  ) dut1 (
    .clk_50Mhz(clk), .reset_n(reset_n), .pix(if1), .clear_err(clear_err),
    .led_out(led1), .busy(busy1), .frame_done(fd1), .underrun(ur1)
  );

  always #10 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc_n = 0;
  int n_acc [2] = '{0, 0};
  int acc_t [2] = '{0, 0};
  int tail  [2] = '{-1, -1};
  int fd_cnt[2] = '{0, 0};
  int fd_t  [2] = '{0, 0};
  int ur_cnt[2] = '{0, 0};
  int ur_t  [2] = '{0, 0};
  int ur_hi [2] = '{0, 0};
  int ones  [2] = '{0, 0};
  int rises [2] = '{0, 0};
  int rise_t[2] = '{0, 0};
  int fall_t[2] = '{0, 0};
  int pend_hi[2] = '{0, 0};
  int pend_lo[2] = '{0, 0};
  bit pend   [2] = '{1'b0, 1'b0};
  logic led_prev[2] = '{1'b0, 1'b0};
  logic ur_prev [2] = '{1'b0, 1'b0};
  bit mon_en = 1'b1;
  pulse_t q0[$];
  pulse_t q1[$];
  vec_t vt[5];

  task automatic chk(input string nm, input int act, input int exp_v);
    nchk++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc_n);
    end
  endtask

  // Expected pulse per bit; the last bit's low time depends on what follows the word.
  task automatic push_pixel(input int k, input logic [31:0] d);
    pulse_t p;
    for (int b = BPP[k] - 1; b >= 0; b--) begin
      p.hi = d[b] ? T1H[k] : T0H[k];
      if (b != 0)         p.lo = TBIT[k] - p.hi;
      else if (tail[k] < 0) p.lo = -1;
      else                p.lo = TBIT[k] - p.hi + tail[k];
      if (k == 0) q0.push_back(p);
      else        q1.push_back(p);
    end
  endtask

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (if0.pix_valid && if0.pix_ready) begin
      acc_t[0] <= cyc_n + 1;
      n_acc[0] <= n_acc[0] + 1;
      push_pixel(0, {8'h00, if0.pix_data});
    end
    if (if1.pix_valid && if1.pix_ready) begin
      acc_t[1] <= cyc_n + 1;
      n_acc[1] <= n_acc[1] + 1;
      push_pixel(1, if1.pix_data);
    end
  end

  task automatic mon_step(input int k, input logic l, input logic fd, input logic u);
    int sz;
    pulse_t p;
    if (fd) begin fd_cnt[k]++; fd_t[k] = cyc_n; end
    if (u) ur_hi[k]++;
    if (u && !ur_prev[k]) begin ur_cnt[k]++; ur_t[k] = cyc_n; end
    ur_prev[k] = u;
    if (!mon_en) begin
      pend[k] = 1'b0;
      led_prev[k] = l;
      return;
    end
    if (l && !led_prev[k]) begin
      rises[k]++;
      if (pend[k] && pend_lo[k] >= 0)
        chk($sformatf("low_width%0d", k), cyc_n - fall_t[k], pend_lo[k]);
      sz = (k == 0) ? q0.size() : q1.size();
      chk($sformatf("pulse_expected%0d", k), int'(sz > 0), 1);
      pend[k] = 1'b0;
      if (sz > 0) begin
        if (k == 0) p = q0.pop_front();
        else        p = q1.pop_front();
        pend[k] = 1'b1;
        pend_hi[k] = p.hi;
        pend_lo[k] = p.lo;
      end
      rise_t[k] = cyc_n;
    end else if (!l && led_prev[k]) begin
      fall_t[k] = cyc_n;
      if (pend[k]) chk($sformatf("high_width%0d", k), cyc_n - rise_t[k], pend_hi[k]);
      if (cyc_n - rise_t[k] == T1H[k]) ones[k]++;
    end
    led_prev[k] = l;
  endtask

  always @(negedge clk) begin
    mon_step(0, led0, fd0, ur0);
    mon_step(1, led1, fd1, ur1);
  end

  task automatic send(input int k, input logic [31:0] d, input logic last, input int tl);
    int n0 = n_acc[k];
    bit ok = 1'b0;
    tail[k] = tl;
    if (k == 0) begin
      if0.pix_data = d[23:0]; if0.pix_last = last; if0.pix_valid = 1'b1;
    end else begin
      if1.pix_data = d; if1.pix_last = last; if1.pix_valid = 1'b1;
    end
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (n_acc[k] != n0);
    end
    // Garbage on data/last while valid is low must be ignored.
    if (k == 0) begin
      if0.pix_valid = 1'b0; if0.pix_data = '1; if0.pix_last = 1'b1;
    end else begin
      if1.pix_valid = 1'b0; if1.pix_data = '1; if1.pix_last = 1'b1;
    end
    chk($sformatf("accept%0d", k), int'(ok), 1);
  endtask

  task automatic wait_fd(input int k, input int n0, input int exp_t, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 12000 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (fd_cnt[k] > n0);
    end
    chk({nm, "_fd_count"}, fd_cnt[k] - n0, 1);
    chk({nm, "_fd_time"}, fd_t[k], exp_t);
    chk({nm, "_busy_at_done"}, int'(k == 0 ? busy0 : busy1), 0);
    @(negedge clk); #1;
    chk({nm, "_fd_one_cycle"}, int'(k == 0 ? fd0 : fd1), 0);
  endtask

  task automatic wait_ur(input int u0);
    bit seen = 1'b0;
    for (int i = 0; i < 12000 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (ur_cnt[0] > u0);
    end
    chk("underrun_seen", ur_cnt[0] - u0, 1);
  endtask

  initial begin
    int e;
    int n0;
    int a0;
    int u0;
    int r0;
    bit hit;
    vt[0] = '{32'h00800001, 2};
    vt[1] = '{32'h00000000, 0};
    vt[2] = '{32'h00FFFFFF, 24};
    vt[3] = '{32'h00A5A5A5, 12};
    vt[4] = '{32'h00123456, 9};

    if0.pix_valid = 1'b0; if0.pix_data = '0; if0.pix_last = 1'b0;
    if1.pix_valid = 1'b0; if1.pix_data = '0; if1.pix_last = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", int'(led0), 0);
    chk("rst_ready", int'(if0.pix_ready), 1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_frame_done", int'(fd0), 0);
    chk("rst_underrun", int'(ur0), 0);
    chk("rst_led_sweep", int'(led1), 0);
    chk("rst_ready_sweep", int'(if1.pix_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single-pixel frames from the vector table.
    for (int i = 0; i < 5; i++) begin
      n0 = fd_cnt[0];
      ones[0] = 0;
      send(0, vt[i].data, 1'b1, -1);
      e = acc_t[0];
      @(posedge clk); #1;
      chk($sformatf("row%0d_busy", i), int'(busy0), 1);
      chk($sformatf("row%0d_ready", i), int'(if0.pix_ready), 1);
      wait_fd(0, n0, e + 1 + BPP[0] * TBIT[0] + RST[0], $sformatf("row%0d", i));
      chk($sformatf("row%0d_ones", i), ones[0], vt[i].ones);
    end

    // Three words back-to-back with valid held high.
    n0 = fd_cnt[0];
    a0 = n_acc[0];
    send(0, 32'h00AA5500, 1'b0, 0);
    e = acc_t[0];
    send(0, 32'h0000FF00, 1'b0, 0);
    chk("b2b_second_edge", acc_t[0], e + 2);
    chk("b2b_ready_when_full", int'(if0.pix_ready), 0);
    send(0, 32'h000000FF, 1'b1, -1);
    chk("b2b_transfers", n_acc[0] - a0, 3);
    wait_fd(0, n0, e + 1 + 3 * BPP[0] * TBIT[0] + RST[0], "b2b");

    // Underrun after a non-final word.
    n0 = fd_cnt[0];
    u0 = ur_cnt[0];
    send(0, 32'h005A5A5A, 1'b0, -1);
    e = acc_t[0];
    wait_ur(u0);
    chk("ur_time", ur_t[0], e + 1 + BPP[0] * TBIT[0] + RST[0]);
    chk("ur_no_fd", fd_cnt[0] - n0, 0);
    chk("ur_busy", int'(busy0), 0);
    chk("ur_flag", int'(ur0), 1);
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    #1;
    chk("ur_cleared", int'(ur0), 0);

    // Underrun set while clear_err is held: the set wins for exactly one cycle.
    u0 = ur_cnt[0];
    clear_err = 1'b1;
    ur_hi[0] = 0;
    send(0, 32'h000F0F0F, 1'b0, -1);
    e = acc_t[0];
    wait_ur(u0);
    chk("ur_setwins_time", ur_t[0], e + 1 + BPP[0] * TBIT[0] + RST[0]);
    repeat (2) @(negedge clk);
    #1;
    chk("ur_setwins_width", ur_hi[0], 1);
    clear_err = 1'b0;

    // 100-cycle starvation between two words of one frame.
    n0 = fd_cnt[0];
    u0 = ur_cnt[0];
    send(0, 32'h00C00003, 1'b0, 100);
    e = acc_t[0];
    while (cyc_n < e + BPP[0] * TBIT[0] + 99) begin
      @(posedge clk); #1;
    end
    chk("stall_busy", int'(busy0), 1);
    chk("stall_led", int'(led0), 0);
    send(0, 32'h003C3C3C, 1'b1, -1);
    chk("stall_push_edge", acc_t[0], e + BPP[0] * TBIT[0] + 100);
    wait_fd(0, n0, acc_t[0] + 1 + BPP[0] * TBIT[0] + RST[0], "stall");
    chk("stall_no_underrun", ur_cnt[0] - u0, 0);
    chk("stall_underrun_flag", int'(ur0), 0);

    // Reset while bit 10 of a word is on the line and another word is held.
    r0 = rises[0];
    send(0, 32'h00FFF000, 1'b0, -1);
    send(0, 32'h0000000F, 1'b1, -1);
    chk("mid_ready_held", int'(if0.pix_ready), 0);
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk); #1;
      hit = (rises[0] >= r0 + 14);
    end
    chk("mid_reached_bit10", int'(hit), 1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_led", int'(led0), 0);
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_ready", int'(if0.pix_ready), 1);
    q0.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 mon_en = 1'b1;
    n0 = fd_cnt[0];
    send(0, 32'h00F00001, 1'b1, -1);
    wait_fd(0, n0, acc_t[0] + 1 + BPP[0] * TBIT[0] + RST[0], "post_rst");

    // Fast 32-bit configuration.
    n0 = fd_cnt[1];
    ones[1] = 0;
    send(1, 32'hF0000000, 1'b1, -1);
    e = acc_t[1];
    wait_fd(1, n0, e + 1 + BPP[1] * TBIT[1] + RST[1], "sweep");
    chk("sweep_ones", ones[1], 4);

    repeat (5) @(negedge clk);
    chk("left_expected0", q0.size(), 0);
    chk("left_expected1", q1.size(), 0);
    chk("total_frames0", fd_cnt[0], 8);
    chk("total_frames1", fd_cnt[1], 1);
    chk("total_underruns0", ur_cnt[0], 2);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: reached cycle %0d, limit 95000", cyc_n);
    $fatal(1, "bench timeout");
  end

endmodule
